mpx_stat: RTL

Windowed level-statistics engine for the 8-bit MPX sample stream, sitting between the MPX datapath and mpx_regs.
- Consumes stat_cfg and stat_limit from mpx_regs.
- Measures min, max and rail-clip count over windows of stat_limit samples.
- Publishes each completed window's results on stat_min/stat_max/stat_count, which mpx_regs reads back over APB.

---
 rtl/mpx_pkg.sv | 18 +
 rtl/mpx_stat_cmp.sv | 40 ++++
 rtl/mpx_stat.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mpx_pkg.sv
// Shared definitions for the MPX statistics block: stat_cfg bit positions,
// statistics FSM states and the rail-clip sample codes.
package mpx_pkg;

  localparam int STAT_CFG_EN_BIT     = 0;
  localparam int STAT_CFG_SIGNED_BIT = 1;

  typedef enum logic [0:0] {
    STAT_IDLE,
    STAT_ACCUM
  } stat_state_t;

  localparam logic [7:0] CLIP_U_LO = 8'h00;
  localparam logic [7:0] CLIP_U_HI = 8'hFF;
  localparam logic [7:0] CLIP_S_LO = 8'h80;
  localparam logic [7:0] CLIP_S_HI = 8'h7F;

endpackage

// File: rtl/mpx_stat_cmp.sv
// Combinational evaluation of one MPX sample against the running window
// accumulators: next min, next max and whether the sample sits on a rail.
// The first sample of a window seeds both min and max.
import mpx_pkg::*;

module mpx_stat_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] min_acc,
  input  logic [DATA_W-1:0] max_acc,
  input  logic              signed_mode,
  input  logic              first,
  output logic [DATA_W-1:0] new_min,
  output logic [DATA_W-1:0] new_max,
  output logic              is_clip
);

  // Pick the new extremes in the selected number format and flag rail samples
  always_comb begin
    new_min = min_acc;
    new_max = max_acc;
    is_clip = 1'b0;
    if (first) begin
      new_min = sample;
      new_max = sample;
    end else if (signed_mode) begin
      if ($signed(sample) < $signed(min_acc)) new_min = sample;
      if ($signed(sample) > $signed(max_acc)) new_max = sample;
    end else begin
      if (sample < min_acc) new_min = sample;
      if (sample > max_acc) new_max = sample;
    end
    if (signed_mode)
      is_clip = (sample == DATA_W'(CLIP_S_LO)) || (sample == DATA_W'(CLIP_S_HI));
    else
      is_clip = (sample == DATA_W'(CLIP_U_LO)) || (sample == DATA_W'(CLIP_U_HI));
  end

endmodule

// File: rtl/mpx_stat.sv
// Windowed level statistics for the MPX sample stream. Tracks min, max and
// rail-clip count over windows of stat_limit valid samples and publishes the
// results of every completed window to mpx_regs.
// Optional build macro MPX_STAT_DONE_EN adds the stat_done publish pulse.
import mpx_pkg::*;

module mpx_stat #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic [1:0]        stat_cfg,
  input  logic [CNT_W-1:0]  stat_limit,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max,
  output logic [CNT_W-1:0]  stat_count
`ifdef MPX_STAT_DONE_EN
  ,
  output logic              stat_done
`endif
);

  stat_state_t       state;
  logic [CNT_W-1:0]  limit_q;
  logic              mode_q;
  logic [CNT_W-1:0]  n;
  logic [DATA_W-1:0] min_acc;
  logic [DATA_W-1:0] max_acc;
  logic [CNT_W-1:0]  clip_acc;

  logic              cfg_en;
  logic              cfg_signed;
  logic              limit_nz;
  logic              first;
  logic              last;
  logic              publish;
  logic [DATA_W-1:0] new_min;
  logic [DATA_W-1:0] new_max;
  logic              is_clip;
  logic [CNT_W-1:0]  clip_next;

  assign cfg_en     = stat_cfg[STAT_CFG_EN_BIT];
  assign cfg_signed = stat_cfg[STAT_CFG_SIGNED_BIT];
  assign limit_nz   = (stat_limit != '0);
  assign first      = (n == '0);
  // limit_q is never zero while accumulating, so limit_q-1 cannot wrap
  assign last       = (n == limit_q - CNT_W'(1));
  assign publish    = (state == STAT_ACCUM) && cfg_en && sample_valid && last;

  mpx_stat_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .sample      (sample),
    .min_acc     (min_acc),
    .max_acc     (max_acc),
    .signed_mode (mode_q),
    .first       (first),
    .new_min     (new_min),
    .new_max     (new_max),
    .is_clip     (is_clip)
  );

  // Clip count saturates instead of wrapping on very long windows
  always_comb begin
    clip_next = clip_acc;
    if (is_clip && (clip_acc != '1)) clip_next = clip_acc + CNT_W'(1);
  end

  // Window FSM: latch config at window start, accumulate, publish on close
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STAT_IDLE;
      limit_q    <= '0;
      mode_q     <= 1'b0;
      n          <= '0;
      min_acc    <= '0;
      max_acc    <= '0;
      clip_acc   <= '0;
      stat_min   <= '0;
      stat_max   <= '0;
      stat_count <= '0;
    end else begin
      case (state)
        STAT_IDLE: begin
          if (cfg_en && limit_nz) begin
            limit_q  <= stat_limit;
            mode_q   <= cfg_signed;
            n        <= '0;
            min_acc  <= '0;
            max_acc  <= '0;
            clip_acc <= '0;
            state    <= STAT_ACCUM;
          end
        end
        STAT_ACCUM: begin
          if (!cfg_en) begin
            n        <= '0;
            min_acc  <= '0;
            max_acc  <= '0;
            clip_acc <= '0;
            state    <= STAT_IDLE;
          end else if (sample_valid) begin
            if (last) begin
              stat_min   <= new_min;
              stat_max   <= new_max;
              stat_count <= clip_next;
              n          <= '0;
              min_acc    <= '0;
              max_acc    <= '0;
              clip_acc   <= '0;
              if (limit_nz) begin
                limit_q <= stat_limit;
                mode_q  <= cfg_signed;
              end else begin
                state <= STAT_IDLE;
              end
            end else begin
              min_acc  <= new_min;
              max_acc  <= new_max;
              clip_acc <= clip_next;
              n        <= n + CNT_W'(1);
            end
          end
        end
        default: state <= STAT_IDLE;
      endcase
    end
  end

`ifdef MPX_STAT_DONE_EN
  // One-cycle pulse aligned with the cycle the new results become visible
  always_ff @(posedge clk) begin
    if (reset) stat_done <= 1'b0;
    else       stat_done <= publish;
  end
`else
  logic unused_publish;
  assign unused_publish = publish;
`endif

endmodule
